// File: rtl/seg7_pkg.sv
// Shared types and segment constants for the multiplexed 7-segment scanner.
// Segment patterns are active-low with bit 7 (dp) off.
package seg7_pkg;

    typedef enum logic [0:0] {
        StShow = 1'b0,
        StGap  = 1'b1
    } scan_state_e;

    localparam logic [7:0] SEG_OFF  = 8'hFF;
    localparam logic [7:0] SEG_DASH = 8'hBF;

    // Index k holds the pattern for digit value k.
    localparam logic [9:0][7:0] SEG_TABLE = {
        8'h90, 8'h80, 8'hF8, 8'h82, 8'h92,
        8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD-to-cathode encoder.
// Non-decimal values render as a dash; blank forces every segment off.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] value,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] cathode
);

    logic [7:0] seg;

    always_comb begin
        seg = SEG_DASH;
        if (value <= 4'd9) begin
            seg = SEG_TABLE[value];
        end
        if (blank) begin
            cathode = SEG_OFF;
        end else begin
            cathode = {~dp, seg[6:0]};
        end
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Four-digit multiplexed 7-segment scanner with a dead gap per slot and a
// one-deep pending register so the displayed value only changes between frames.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int unsigned SLOT_CYCLES = 10000,
    parameter int unsigned DEAD_CYCLES = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] load_data,
    input  logic [3:0]  load_dp,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic        lzs,
    output logic [3:0]  anode,
    output logic [7:0]  cathode,
    output logic        frame_start
);

    localparam int unsigned CntW        = $clog2(SLOT_CYCLES);
    localparam int unsigned ShowCycles  = SLOT_CYCLES - DEAD_CYCLES;
    localparam logic [CntW-1:0] ShowLast = CntW'(ShowCycles - 1);
    localparam logic [CntW-1:0] GapLast  = CntW'(DEAD_CYCLES - 1);

    scan_state_e     state_q;
    logic [1:0]      idx_q;
    logic [CntW-1:0] cnt_q;
    logic [15:0]     active_q;
    logic [3:0]      active_dp_q;
    logic [15:0]     pend_q;
    logic [3:0]      pend_dp_q;
    logic            pend_full_q;

    logic            slot_last;
    logic            boundary;
    logic            higher_zero;
    logic            blank;
    logic [3:0]      digit;
    logic [3:0]      anode_d;
    logic [7:0]      cathode_d;

    assign load_ready  = !pend_full_q;
    assign slot_last   = (state_q == StShow) ? (cnt_q == ShowLast) : (cnt_q == GapLast);
    assign boundary    = (state_q == StGap) && (cnt_q == GapLast) && (idx_q == 2'd3);
    assign digit       = active_q[{idx_q, 2'b00} +: 4];
    // True when this digit and every digit above it are zero.
    assign higher_zero = (active_q >> {idx_q, 2'b00}) == 16'h0000;
    assign blank       = (state_q == StGap) || (lzs && (idx_q != 2'd0) && higher_zero);
    assign anode_d     = blank ? 4'hF : ~(4'b0001 << idx_q);

    seg7_decode u_decode (
        .value   (digit),
        .dp      (active_dp_q[idx_q]),
        .blank   (blank),
        .cathode (cathode_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StShow;
            idx_q       <= 2'd0;
            cnt_q       <= '0;
            active_q    <= 16'h0000;
            active_dp_q <= 4'h0;
            pend_q      <= 16'h0000;
            pend_dp_q   <= 4'h0;
            pend_full_q <= 1'b0;
            anode       <= 4'hF;
            cathode     <= SEG_OFF;
            frame_start <= 1'b0;
        end else begin
            anode       <= anode_d;
            cathode     <= cathode_d;
            frame_start <= boundary;

            if (slot_last) begin
                cnt_q <= '0;
                if (state_q == StShow) begin
                    state_q <= StGap;
                end else begin
                    state_q <= StShow;
                    idx_q   <= idx_q + 2'd1;
                end
            end else begin
                cnt_q <= cnt_q + CntW'(1);
            end

            if (boundary && pend_full_q) begin
                active_q    <= pend_q;
                active_dp_q <= pend_dp_q;
            end

            // A load coinciding with the boundary lands in pending only.
            if (load_valid && !pend_full_q) begin
                pend_q      <= load_data;
                pend_dp_q   <= load_dp;
                pend_full_q <= 1'b1;
            end else if (boundary) begin
                pend_full_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: directed scenarios plus random loads, all checked
// every cycle against a frame-time arithmetic model of the display.
module tb_seg7_scan_ctrl;

    localparam int Slot = 8;
    localparam int Dead = 2;
    localparam int Frame = 4 * Slot;
    localparam logic [7:0] SegTab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                           8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] load_data = 16'h0000;
    logic [3:0]  load_dp = 4'h0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic        lzs = 1'b0;
    logic [3:0]  anode;
    logic [7:0]  cathode;
    logic        frame_start;

    seg7_scan_ctrl #(
        .SLOT_CYCLES (Slot),
        .DEAD_CYCLES (Dead)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load_data   (load_data),
        .load_dp     (load_dp),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .lzs         (lzs),
        .anode       (anode),
        .cathode     (cathode),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Model: n counts cycles since reset; everything derives from n mod Frame.
    int          n = 0;
    logic [15:0] m_act = 16'h0, m_pend = 16'h0;
    logic [3:0]  m_act_dp = 4'h0, m_pend_dp = 4'h0;
    bit          m_full = 1'b0;
    bit          m_acc = 1'b0;
    logic [3:0]  e_an = 4'hF;
    logic [7:0]  e_ca = 8'hFF;
    logic        e_fs = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        int pos;
        int idx;
        logic [3:0] dig;
        bit old_full;
        m_acc = 1'b0;
        if (rst) begin
            e_an = 4'hF; e_ca = 8'hFF; e_fs = 1'b0;
            n = 0; m_act = 16'h0; m_act_dp = 4'h0; m_full = 1'b0;
        end else begin
            pos = n % Slot;
            idx = (n / Slot) % 4;
            dig = m_act[idx*4 +: 4];
            if (pos >= Slot - Dead || (lzs && idx > 0 && (m_act >> (4 * idx)) == 16'h0)) begin
                e_an = 4'hF;
                e_ca = 8'hFF;
            end else begin
                e_an = ~(4'(1) << idx);
                e_ca = (dig < 4'd10) ? SegTab[dig] : 8'hBF;
                if (m_act_dp[idx]) e_ca[7] = 1'b0;
            end
            e_fs = (n % Frame) == Frame - 1;
            old_full = m_full;
            if (e_fs && old_full) begin
                m_act = m_pend; m_act_dp = m_pend_dp; m_full = 1'b0;
            end
            if (load_valid && !old_full) begin
                m_pend = load_data; m_pend_dp = load_dp; m_full = 1'b1; m_acc = 1'b1;
            end
            n++;
        end
    endtask

    // One clock: update the model at the edge, compare just after, and let the
    // requester drop its offer once it has been taken.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("anode", 32'(anode), 32'(e_an));
        check("cathode", 32'(cathode), 32'(e_ca));
        check("frame_start", 32'(frame_start), 32'(e_fs));
        check("load_ready", 32'(load_ready), 32'(!m_full));
        if (m_acc) load_valid = 1'b0;
    endtask

    task automatic offer(input logic [15:0] d, input logic [3:0] p);
        load_data = d; load_dp = p; load_valid = 1'b1;
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) step();
    endtask

    task automatic wait_accept(input string tag);
        int k = 0;
        do begin step(); k++; end while (!m_acc && k < 100);
        check(tag, 32'(load_ready), 32'(0));
    endtask

    int first_fs, second_fs, k;
    logic [15:0] masks [5] = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F, 16'h0000};

    initial begin
        // Reset behaviour.
        rst = 1'b1;
        run(3);
        check("rst_anode", 32'(anode), 32'hF);
        check("rst_cathode", 32'(cathode), 32'hFF);
        check("rst_ready", 32'(load_ready), 32'h1);
        check("rst_fs", 32'(frame_start), 32'h0);

        // First frame shows zeros; loaded 1234 appears after the boundary.
        rst = 1'b0;
        offer(16'h1234, 4'b0000);
        step();
        check("f0_dig0", 32'(cathode), 32'hC0);
        k = 0;
        while (!frame_start && k < 40) begin step(); k++; end
        step();
        check("f1_anode", 32'(anode), 32'hE);
        check("f1_dig0", 32'(cathode), 32'h99);

        // Frame period.
        first_fs = -1; second_fs = -1;
        for (int i = 0; i < 80 && second_fs < 0; i++) begin
            step();
            if (frame_start) begin
                if (first_fs < 0) first_fs = i;
                else second_fs = i;
            end
        end
        check("fs_period", 32'(second_fs - first_fs), 32'(Frame));

        // Blanking and dash.
        lzs = 1'b1;
        offer(16'h0050, 4'h0); run(2 * Frame);
        offer(16'h0000, 4'h0); run(2 * Frame);
        lzs = 1'b0;
        offer(16'h00A0, 4'h5); run(2 * Frame);

        // Back-pressure: B held while A sits in pending.
        offer(16'h9876, 4'h2);
        wait_accept("a_accept");
        offer(16'h4321, 4'h8);
        run(3 * Frame);

        // Reset mid-frame with pending full and digit 2 lit.
        offer(16'h5678, 4'h0);
        wait_accept("x_accept");
        offer(16'h8765, 4'h1);
        wait_accept("y_accept");
        k = 0;
        while ((n % Frame) != 2 * Slot + 2 && k < 40) begin step(); k++; end
        check("pre_rst_anode", 32'(anode), 32'hB);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_anode", 32'(anode), 32'hF);
        check("mid_rst_ready", 32'(load_ready), 32'h1);
        load_valid = 1'b0;
        run(Frame + 4);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if (!load_valid && $urandom_range(0, 99) < 10)
                offer(16'($urandom) & masks[$urandom_range(0, 4)], 4'($urandom));
            if ($urandom_range(0, 99) < 2) lzs = ~lzs;
            rst = ($urandom_range(0, 599) == 0);
            step();
        end
        rst = 1'b0;
        run(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
